// File: rtl/axis_video_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_video_frame_checker
//
// AXI4-Stream video sink for the output of stream_video_filter. Pixels are
// accepted under a registered tready. Each pixel's x/y position is tracked
// against the configured frame geometry. SOF (tuser) and EOL (tlast) framing
// violations are flagged, and good and bad frames are counted. On a framing
// error the checker resynchronises on the next SOF.
//
// Optional build macro: FRAME_SUM_EN
//   When defined, a modulo-2^32 sum of the tdata of each frame is latched on
//   frame completion and strobed with frame_done.
//   When undefined, frame_sum and frame_sum_valid are tied to zero.
//
// Handshake: a beat transfers on a rising clk edge where both tvalid and tready
// are high. tready is the registered copy of sink_en, so it lags sink_en by one
// cycle. Once tready is high, any beat presented is consumed; no beat is ever
// refused.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   s_axis_video_*         AXI4-Stream slave (tdata/tvalid/tready/tuser/tlast)
//   sink_en                ready request, becomes tready one cycle later
//   err_clear              clears the sticky err_* flags
//   x_pos, y_pos           next expected pixel index / current line index
//   in_frame               1 while the checker is locked to a frame (ACTIVE)
//   frame_done             one-cycle pulse after the last pixel of a frame
//   good_frames/bad_frames wrapping 16-bit frame counters
//   err_sof_early/err_sof_missing/err_eol_early/err_eol_late  sticky flags
//   frame_sum/frame_sum_valid  optional per-frame checksum and strobe
// -----------------------------------------------------------------------------
module axis_video_frame_checker #(
   parameter int DATA_WIDTH   = 24,
   parameter int FRAME_WIDTH  = 20,
   parameter int FRAME_HEIGHT = 10,
   parameter int CNT_WIDTH    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
   input  logic                  s_axis_video_tvalid,
   output logic                  s_axis_video_tready,
   input  logic                  s_axis_video_tuser,
   input  logic                  s_axis_video_tlast,
   input  logic                  sink_en,
   input  logic                  err_clear,
   output logic [CNT_WIDTH-1:0]  x_pos,
   output logic [CNT_WIDTH-1:0]  y_pos,
   output logic                  in_frame,
   output logic                  frame_done,
   output logic [15:0]           good_frames,
   output logic [15:0]           bad_frames,
   output logic                  err_sof_early,
   output logic                  err_sof_missing,
   output logic                  err_eol_early,
   output logic                  err_eol_late,
   output logic [31:0]           frame_sum,
   output logic                  frame_sum_valid
);

   localparam logic [0:0] ST_WAIT_SOF = 1'b0;
   localparam logic [0:0] ST_ACTIVE   = 1'b1;

   localparam logic [CNT_WIDTH-1:0] X_LAST  = CNT_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] Y_LAST  = CNT_WIDTH'(FRAME_HEIGHT - 1);
   // Position after pixel (0,0). A one-pixel-wide line ends on its own SOF beat.
   localparam logic [CNT_WIDTH-1:0] X_FIRST = CNT_WIDTH'((FRAME_WIDTH > 1) ? 1 : 0);

   logic [0:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic                 ready_q;
   logic                 ferr_q, ferr_d;      // current frame already contains an error
   logic                 done_q, done_d;
   logic [15:0]          good_q, good_d, bad_q, bad_d;
   logic                 sofe_q, sofe_d, sofm_q, sofm_d;
   logic                 eole_q, eole_d, eoll_q, eoll_d;

   logic                 beat;
   logic                 at_origin;
   logic                 start;
   logic                 line_end;
   logic                 good_inc, bad_inc;
   logic                 new_sofe, new_sofm, new_eole, new_eoll;
   logic [CNT_WIDTH-1:0] line_y;

   assign beat      = s_axis_video_tvalid & ready_q;
   assign at_origin = (x_q == '0) && (y_q == '0);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      ferr_d   = ferr_q;
      done_d   = 1'b0;
      start    = 1'b0;
      line_end = 1'b0;
      good_inc = 1'b0;
      bad_inc  = 1'b0;
      new_sofe = 1'b0;
      new_sofm = 1'b0;
      new_eole = 1'b0;
      new_eoll = 1'b0;
      line_y   = y_q;

      if (beat) begin
         if (state_q == ST_WAIT_SOF) begin
            // Beats without SOF are consumed and dropped while hunting.
            if (s_axis_video_tuser) start = 1'b1;
         end else if (s_axis_video_tuser && !at_origin) begin
            // Premature SOF: abort the open frame and restart on this beat.
            new_sofe = 1'b1;
            bad_inc  = 1'b1;
            start    = 1'b1;
         end else if (!s_axis_video_tuser && at_origin) begin
            // Frame boundary without SOF: no frame is open, so nothing is counted.
            new_sofm = 1'b1;
            state_d  = ST_WAIT_SOF;
         end else if (s_axis_video_tuser) begin
            start = 1'b1;
         end else if (s_axis_video_tlast && (x_q != X_LAST)) begin
            new_eole = 1'b1;
            ferr_d   = 1'b1;
            line_end = 1'b1;
         end else if (!s_axis_video_tlast && (x_q == X_LAST)) begin
            // Missing EOL: line boundary lost, abandon the frame.
            new_eoll = 1'b1;
            bad_inc  = 1'b1;
            state_d  = ST_WAIT_SOF;
            x_d      = '0;
            y_d      = '0;
         end else if (x_q == X_LAST) begin
            line_end = 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      if (start) begin
         state_d = ST_ACTIVE;
         ferr_d  = 1'b0;
         x_d     = X_FIRST;
         y_d     = '0;
         line_y  = '0;
         if (FRAME_WIDTH == 1) line_end = 1'b1;
      end

      if (line_end) begin
         x_d = '0;
         if (line_y == Y_LAST) begin
            y_d    = '0;
            done_d = 1'b1;
            if (ferr_d) bad_inc  = 1'b1;
            else        good_inc = 1'b1;
         end else begin
            y_d = line_y + 1'b1;
         end
      end

      good_d = good_q + {15'd0, good_inc};
      bad_d  = bad_q + {15'd0, bad_inc};

      // A new error in the same cycle as err_clear leaves the flag set.
      sofe_d = (sofe_q & ~err_clear) | new_sofe;
      sofm_d = (sofm_q & ~err_clear) | new_sofm;
      eole_d = (eole_q & ~err_clear) | new_eole;
      eoll_d = (eoll_q & ~err_clear) | new_eoll;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_WAIT_SOF;
         x_q     <= '0;
         y_q     <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         good_q  <= '0;
         bad_q   <= '0;
         sofe_q  <= 1'b0;
         sofm_q  <= 1'b0;
         eole_q  <= 1'b0;
         eoll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ready_q <= sink_en;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         sofe_q  <= sofe_d;
         sofm_q  <= sofm_d;
         eole_q  <= eole_d;
         eoll_q  <= eoll_d;
      end
   end

   assign s_axis_video_tready = ready_q;
   assign x_pos               = x_q;
   assign y_pos               = y_q;
   assign in_frame            = (state_q == ST_ACTIVE);
   assign frame_done          = done_q;
   assign good_frames         = good_q;
   assign bad_frames          = bad_q;
   assign err_sof_early       = sofe_q;
   assign err_sof_missing     = sofm_q;
   assign err_eol_early       = eole_q;
   assign err_eol_late        = eoll_q;

`ifdef FRAME_SUM_EN
   logic [31:0] acc_q, acc_d, sum_q, sum_d;
   logic        sumv_q, sumv_d;

   always_comb begin
      acc_d  = acc_q;
      sum_d  = sum_q;
      sumv_d = 1'b0;
      // In-frame non-SOF beats are exactly those reaching the EOL checks.
      if (start) begin
         acc_d = 32'(s_axis_video_tdata);
      end else if (beat && (state_q == ST_ACTIVE) && !s_axis_video_tuser && !at_origin) begin
         acc_d = acc_q + 32'(s_axis_video_tdata);
      end
      if (done_d) begin
         sum_d  = acc_d;
         sumv_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q  <= '0;
         sum_q  <= '0;
         sumv_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         sum_q  <= sum_d;
         sumv_q <= sumv_d;
      end
   end

   assign frame_sum       = sum_q;
   assign frame_sum_valid = sumv_q;
`else
   assign frame_sum       = '0;
   assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: doc/axis_video_frame_checker.md
Name: axis_video_frame_checker

Overview:
- AXI4-Stream video sink that consumes the output of stream_video_filter and checks its framing.
- Accepts pixels under a controllable tready, tracks x/y position against the configured frame geometry, and flags SOF/EOL protocol violations.
- Counts good and bad frames and resynchronises on errors; bench- and debug-side receiver for the video pipeline.

Parameters:
DATA_WIDTH, 24, pixel bus width
FRAME_WIDTH, 20, pixels per line
FRAME_HEIGHT, 10, lines per frame
CNT_WIDTH, 12, x/y counter width (must hold FRAME_WIDTH-1 and FRAME_HEIGHT-1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
s_axis_video_tdata  in  DATA_WIDTH  pixel data
s_axis_video_tvalid  in  1  source valid
s_axis_video_tready  out  1  sink ready (registered)
s_axis_video_tuser  in  1  start of frame
s_axis_video_tlast  in  1  end of line
sink_en  in  1  ready request; tready follows one cycle later
err_clear  in  1  clears sticky error flags
x_pos  out  CNT_WIDTH  next expected pixel index in line
y_pos  out  CNT_WIDTH  current line index
in_frame  out  1  1 in ACTIVE state
frame_done  out  1  one-cycle pulse after last pixel of a frame
good_frames  out  16  error-free completed frames, wraps at 65535
bad_frames  out  16  completed or aborted frames containing an error, wraps
err_sof_early  out  1  sticky: tuser seen mid-frame
err_sof_missing  out  1  sticky: first pixel of frame lacks tuser
err_eol_early  out  1  sticky: tlast before x = FRAME_WIDTH-1
err_eol_late  out  1  sticky: no tlast at x = FRAME_WIDTH-1
frame_sum  out  32  optional checksum (see below)
frame_sum_valid  out  1  optional checksum strobe

Behaviour:
- Reset (rst=0 at clk edge): tready=0, x_pos=y_pos=0, state WAIT_SOF, in_frame=0, frame_done=0, counters=0, all err_*=0, frame_sum=0, frame_sum_valid=0.
- tready <= sink_en every cycle. Beat accepted iff tvalid & tready. No beat is ever rejected once accepted.
- WAIT_SOF:
  - Beats with tuser=0 are accepted and discarded.
  - A beat with tuser=1 is pixel (0,0): go to ACTIVE, x=1 (or line end handling if FRAME_WIDTH=1), y=0, per-frame error flag cleared.
- ACTIVE, on each accepted beat (checks in priority order):
  - 1. tuser=1 and (x,y)≠(0,0): set err_sof_early, bad_frames+1. Beat restarts the frame as pixel (0,0).
  - 2. tuser=0 and (x,y)=(0,0): set err_sof_missing, go to WAIT_SOF. Nothing counted (no frame open).
  - 3. tlast=1 and x<FRAME_WIDTH-1: set err_eol_early, mark frame bad, treat as end of line.
  - 4. tlast=0 and x=FRAME_WIDTH-1: set err_eol_late, bad_frames+1, go to WAIT_SOF.
  - 5. Otherwise x+1, or end of line at x=FRAME_WIDTH-1.
- End of line: x=0, y+1. At y=FRAME_HEIGHT-1 the frame completes:
  - y=0, state stays ACTIVE.
  - frame_done=1 on the next cycle.
  - good_frames+1 if the frame had no error, else bad_frames+1.
- Sticky errors hold until err_clear=1. If err_clear and a new error occur in the same cycle, the new error wins (flag = 1).
- sink_en low mid-frame: position is held, and the frame continues when tready returns.
- Counters wrap modulo 2^16; x/y never exceed the geometry.

Optional Feature:
FRAME_SUM_EN
- Defined:
  - frame_sum accumulates the zero-extended tdata of every accepted in-frame beat, modulo 2^32.
  - The accumulator resets at each pixel (0,0).
  - On frame completion, frame_sum is latched and frame_sum_valid pulses together with frame_done.
  - Aborted frames produce no strobe.
- Undefined: frame_sum=0 and frame_sum_valid=0 constantly; no accumulator logic.

Test Plan:
- Reset, sink_en=1, one clean 20x10 frame, tvalid=1 continuous, tdata=1 per pixel -> frame_done once, good_frames=1, all err_*=0; with FRAME_SUM_EN, frame_sum=200.
- Same frame, random tvalid and random sink_en -> identical result to the previous case: good_frames=1, frame_done once, x_pos/y_pos return to 0.
- tlast asserted at x=15 on line 3 -> err_eol_early=1 on next cycle, y_pos=4, frame completes as bad: bad_frames=1, good_frames=0.
- tuser asserted at (7,2) -> err_sof_early=1, bad_frames=1, x_pos=1, y_pos=0; the following clean frame gives good_frames=1.
- 5 beats without tuser after reset, then a clean frame -> the 5 beats are discarded silently, no errors, good_frames=1. Then next frame starts without tuser -> err_sof_missing=1, in_frame=0.
- Error set, then err_clear=1 for one cycle -> flags 0. err_clear coinciding with err_eol_late -> err_eol_late stays 1. rst=0 mid-frame -> all outputs return to reset values next cycle.
